// File: rtl/ped_request_conditioner.sv
// Pedestrian button conditioner: 2-FF sync, counter debounce, rising-edge pulse, request latch; lockout window under PED_LOCKOUT_EN.
// Latency: btn_level follows a stable btn_raw DEBOUNCE_CYCLES+1 edges later; no backpressure, every output registered.
module ped_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LOCKOUT_CYCLES  = 250_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       serve_ack,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       req_pending,
  output logic       lockout,
  output logic [3:0] dup_count
);

  if (DEBOUNCE_CYCLES < 2 || LOCKOUT_CYCLES < 1) begin : g_param_check
    $error("ped_request_conditioner: DEBOUNCE_CYCLES must be >= 2 and LOCKOUT_CYCLES >= 1");
  end

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
`ifdef PED_LOCKOUT_EN
  localparam logic [1:0] LOCKOUT = 2'd2;
  localparam int LK_W = $clog2(LOCKOUT_CYCLES) + 1;
  localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCKOUT_CYCLES - 1);
`endif

  logic            s1;
  logic            s2;
  logic [DB_W-1:0] db_cnt;
  logic            db_flip;

  // A flip needs DEBOUNCE_CYCLES consecutive samples of s2 disagreeing with btn_level.
  assign db_flip = (s2 != btn_level) && (db_cnt == DB_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      btn_level   <= 1'b0;
      press_pulse <= 1'b0;
      db_cnt      <= '0;
    end else begin
      s1          <= btn_raw;
      s2          <= s1;
      press_pulse <= db_flip && s2;
      if (s2 == btn_level) begin
        db_cnt <= '0;
      end else if (db_flip) begin
        btn_level <= s2;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] dup_nxt;
`ifdef PED_LOCKOUT_EN
  logic [LK_W-1:0] lk_cnt;
  logic [LK_W-1:0] lk_cnt_nxt;
`endif

  always_comb begin
    state_nxt = state;
    dup_nxt   = dup_count;
`ifdef PED_LOCKOUT_EN
    lk_cnt_nxt = '0;
`endif
    case (state)
      IDLE: begin
        if (press_pulse) begin
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        // The ack wins over a simultaneous press; that press is dropped.
        if (serve_ack) begin
`ifdef PED_LOCKOUT_EN
          state_nxt = LOCKOUT;
`else
          state_nxt = IDLE;
`endif
          dup_nxt = 4'd0;
        end else if (press_pulse && dup_count != 4'hF) begin
          dup_nxt = dup_count + 4'd1;
        end
      end
`ifdef PED_LOCKOUT_EN
      LOCKOUT: begin
        if (lk_cnt == LK_LAST) begin
          state_nxt = IDLE;
        end else begin
          lk_cnt_nxt = lk_cnt + LK_W'(1);
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      dup_count   <= 4'd0;
      req_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      dup_count   <= dup_nxt;
      req_pending <= (state_nxt == PENDING);
    end
  end

`ifdef PED_LOCKOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      lk_cnt  <= '0;
      lockout <= 1'b0;
    end else begin
      lk_cnt  <= lk_cnt_nxt;
      lockout <= (state_nxt == LOCKOUT);
    end
  end
`else
  assign lockout = 1'b0;
`endif

endmodule

// File: doc/ped_request_conditioner.md
Name: ped_request_conditioner

Overview:
- Upstream input stage for traffic_light_controller.
- Conditions a raw pedestrian push-button: 2-FF synchronizer, then counter-based debouncer, then rising-edge detect.
- Latches a pending crossing request and holds it until the controller acknowledges service via a one-cycle pulse.
- After service, a lockout window stops one held or bouncing press from re-requesting immediately.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, cycles the synchronized input must differ from btn_level before btn_level flips (20 ms at 50 MHz); must be >= 2.
- LOCKOUT_CYCLES, 250_000_000, cycles the block ignores presses after serve_ack (5 s at 50 MHz); must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- btn_raw  in  1  asynchronous push-button, active-high, bouncy.
- serve_ack  in  1  one-cycle pulse from the controller: pedestrian phase granted.
- btn_level  out  1  debounced button level.
- press_pulse  out  1  one-cycle pulse on a debounced rising edge.
- req_pending  out  1  latched request awaiting serve_ack.
- lockout  out  1  high while in the post-service lockout window.
- dup_count  out  4  presses received while already pending; saturating.

Behaviour:
- Reset (reset==0 sampled at posedge clk):
  - sync FFs, btn_level, press_pulse, req_pending, lockout and dup_count all go to 0.
  - Debounce and lockout counters go to 0.
  - FSM goes to IDLE.
  - Reset mid-debounce or mid-lockout discards all progress.
- Synchronizer: btn_raw -> s1 -> s2. The debouncer uses only s2.
- Debouncer:
  - If s2==btn_level: counter cleared.
  - Else: counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with s2 still != btn_level: btn_level<=s2 and counter cleared at that edge.
  - Any single-cycle return of s2 to btn_level clears the counter, so a bounce restarts the count.
  - Latency: btn_raw stable high from edge k gives btn_level=1 after edge k+1+DEBOUNCE_CYCLES.
- press_pulse:
  - Registered; 1 for exactly the cycle in which btn_level first reads 1 after a 0→1 flip.
  - Never asserted on release.
- FSM states: IDLE, PENDING, LOCKOUT.
  - IDLE: press_pulse → PENDING. serve_ack is ignored.
  - PENDING: serve_ack → LOCKOUT, dup_count<=0. press_pulse without serve_ack: dup_count increments, saturating at 15.
  - LOCKOUT: counter counts LOCKOUT_CYCLES, then → IDLE. press_pulse and serve_ack are ignored; no counting.
- Simultaneous events:
  - PENDING with press_pulse and serve_ack in the same cycle: ack wins, press is dropped, dup_count<=0.
  - IDLE with press_pulse and serve_ack in the same cycle: → PENDING.
- Outputs are registered, decoded from the next state:
  - req_pending rises the cycle after press_pulse.
  - req_pending falls the cycle after serve_ack.
  - lockout=1 for exactly LOCKOUT_CYCLES cycles, starting the cycle after serve_ack.
- A button still held when lockout ends does not re-request. A new rising edge is required.
- Counter widths: $clog2 of the respective parameter plus 1. No wrap-around is possible.

Optional Feature:
- Macro: PED_LOCKOUT_EN.
- Defined: LOCKOUT state is present as described above.
- Undefined:
  - serve_ack in PENDING returns directly to IDLE.
  - lockout is tied to 0 and no lockout counter is built.
  - A press_pulse in the cycle after the ack is accepted normally.

Test Plan (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=10, PED_LOCKOUT_EN defined):
- Hold reset=0 for 3 cycles, with btn_raw=1 and serve_ack=1 → all outputs 0. Release → btn_level rises 1+4 cycles later.
- btn_raw high with bounces of 1–3 cycles low, then stable high from edge k:
  - Required: btn_level=1 after edge k+5; one press_pulse; req_pending=1 the cycle after.
  - During the bounces: btn_level stays 0.
- In PENDING, give 3 clean presses (low/high 8 cycles each) → dup_count=3. Then 20 presses → dup_count saturates at 15.
- In PENDING, press_pulse coincident with serve_ack:
  - Next cycle: req_pending=0, lockout=1, dup_count=0.
  - lockout stays high for exactly 10 cycles.
  - A press during lockout gives a press_pulse but no request.
- Button held through the end of lockout → stays IDLE. Release, then press again → PENDING.
- Rebuild without PED_LOCKOUT_EN:
  - serve_ack returns to IDLE; lockout stays 0.
  - A press_pulse 1 cycle after serve_ack sets req_pending=1 again.
